// File: rtl/fp_pack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_pack : packs normalized/rounded FP fields into an IEEE-754 single     |
// |           word and buffers it in a 2-entry FIFO (1-cycle latency).       |
// | Optional: define FP_PACK_FLAGS_EN to add out_flags {overflow,zero,nan}.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        norm_sign,
  input  logic [7:0]  norm_exponent,
  input  logic [22:0] norm_mantissa,
  input  logic        round_carry,
  input  logic        nan_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
`ifdef FP_PACK_FLAGS_EN
  ,
  output logic [2:0]  out_flags
`endif
);

  localparam logic [31:0] c_qnan      = 32'h7FC0_0000;
  localparam logic [7:0]  c_exp_max   = 8'hFF;
  localparam logic [7:0]  c_exp_zero  = 8'h00;
  localparam logic [8:0]  c_exp_inf9  = 9'd255;
  localparam logic [1:0]  c_depth     = 2'd2;
`ifdef FP_PACK_FLAGS_EN
  localparam int          ENTRY_W     = 35;
`else
  localparam int          ENTRY_W     = 32;
`endif

  // ------------------------------------------------------------------
  // Classification of the incoming result (priority-ordered)
  // ------------------------------------------------------------------
  logic [8:0] w_exp_inc;
  logic       w_is_nan;
  logic       w_is_inf;
  logic       w_is_carry_ovf;
  logic       w_is_carry;
  logic       w_is_zero;

  always_comb begin
    // 9-bit increment so a carry out of 254 is seen before truncation
    w_exp_inc      = {1'b0, norm_exponent} + 9'd1;
    w_is_nan       = nan_in;
    w_is_inf       = !w_is_nan && (norm_exponent == c_exp_max);
    w_is_carry_ovf = !w_is_nan && !w_is_inf && round_carry && (w_exp_inc >= c_exp_inf9);
    w_is_carry     = !w_is_nan && !w_is_inf && round_carry && (w_exp_inc <  c_exp_inf9);
    w_is_zero      = !w_is_nan && !w_is_inf && !round_carry && (norm_exponent == c_exp_zero);
  end

  logic [31:0] w_word;

  always_comb begin
    w_word = {norm_sign, norm_exponent, norm_mantissa};
    if (w_is_nan) begin
      w_word = c_qnan;
    end else if (w_is_inf || w_is_carry_ovf) begin
      w_word = {norm_sign, c_exp_max, 23'h0};
    end else if (w_is_carry) begin
      w_word = {norm_sign, w_exp_inc[7:0], 23'h0};
    end else if (w_is_zero) begin
      w_word = {norm_sign, c_exp_zero, 23'h0};
    end
  end

  logic [ENTRY_W-1:0] w_entry;

`ifdef FP_PACK_FLAGS_EN
  logic [2:0] w_flags;

  always_comb begin
    w_flags    = 3'b000;
    w_flags[2] = w_is_inf || w_is_carry_ovf;
    w_flags[1] = w_is_zero;
    w_flags[0] = w_is_nan;
  end

  assign w_entry = {w_flags, w_word};
`else
  assign w_entry = w_word;
`endif

  // ------------------------------------------------------------------
  // Two-entry FIFO
  // ------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [2];
  logic               rd_ptr_q;
  logic               wr_ptr_q;
  logic [1:0]         count_q;
  logic [1:0]         count_d;
  logic               w_push;
  logic               w_pop;

  assign in_ready  = (count_q < c_depth);
  assign out_valid = (count_q != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= w_entry;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  // Head entry drives the outputs directly, so they hold while stalled
  assign out_result = mem_q[rd_ptr_q][31:0];
`ifdef FP_PACK_FLAGS_EN
  assign out_flags  = mem_q[rd_ptr_q][34:32];
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_pack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fp_pack : directed self-checking bench for fp_pack.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fp_pack;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        norm_sign;
  logic [7:0]  norm_exponent;
  logic [22:0] norm_mantissa;
  logic        round_carry;
  logic        nan_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
`ifdef FP_PACK_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  int checks   = 0;
  int failures = 0;

  fp_pack dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .norm_sign     (norm_sign),
    .norm_exponent (norm_exponent),
    .norm_mantissa (norm_mantissa),
    .round_carry   (round_carry),
    .nan_in        (nan_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result)
`ifdef FP_PACK_FLAGS_EN
    ,
    .out_flags     (out_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] exp);
`ifdef FP_PACK_FLAGS_EN
    chk(tag, {29'd0, out_flags}, {29'd0, exp});
`else
    if (exp === 3'bxxx) chk(tag, 32'd0, 32'd1);
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [22:0] m,
                       input logic c, input logic n);
    in_valid      = 1'b1;
    norm_sign     = s;
    norm_exponent = e;
    norm_mantissa = m;
    round_carry   = c;
    nan_in        = n;
  endtask

  // Push one result into an empty FIFO with out_ready low, check, then pop it
  task automatic single(input string tag, input logic s, input logic [7:0] e,
                        input logic [22:0] m, input logic c, input logic n,
                        input logic [31:0] exp_word, input logic [2:0] exp_flags);
    out_ready = 1'b0;
    drive(s, e, m, c, n);
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_word"}, out_result, exp_word);
    chk_flags({tag, "_flags"}, exp_flags);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_empty"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; norm_sign = 1'b0; norm_exponent = 8'h00;
    norm_mantissa = 23'h0; round_carry = 1'b0; nan_in = 1'b0; out_ready = 1'b0;

    tick();
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    out_result,         32'h0000_0000);
    chk_flags("rst_flags", 3'b000);
    tick();
    reset = 1'b0;
    tick();

    // Normal packing with hold under backpressure
    drive(1'b1, 8'h80, 23'h40_0000, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("norm_valid", {31'd0, out_valid}, 32'd1);
    chk("norm_word",  out_result, 32'hC040_0000);
    chk_flags("norm_flags", 3'b000);
    tick();
    chk("norm_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("norm_hold_word",  out_result, 32'hC040_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("norm_popped", {31'd0, out_valid}, 32'd0);

    single("carry",     1'b0, 8'h7F, 23'h0,      1'b1, 1'b0, 32'h4000_0000, 3'b000);
    single("carry_ovf", 1'b0, 8'hFE, 23'h12345,  1'b1, 1'b0, 32'h7F80_0000, 3'b100);
    single("carry_neg", 1'b1, 8'hFE, 23'h0,      1'b1, 1'b0, 32'hFF80_0000, 3'b100);
    single("inf",       1'b1, 8'hFF, 23'h5,      1'b0, 1'b0, 32'hFF80_0000, 3'b100);
    single("nan",       1'b1, 8'hFF, 23'h1,      1'b1, 1'b1, 32'h7FC0_0000, 3'b001);
    single("zero",      1'b1, 8'h00, 23'h123,    1'b0, 1'b0, 32'h8000_0000, 3'b010);
    single("carry_e0",  1'b0, 8'h00, 23'h0,      1'b1, 1'b0, 32'h0080_0000, 3'b000);

    // Backpressure: A and B fill the FIFO, C is held off
    out_ready = 1'b0;
    drive(1'b0, 8'h81, 23'h00_0001, 1'b0, 1'b0);
    tick();
    chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 8'h01, 23'h7F_FFFF, 1'b0, 1'b0);
    tick();
    chk("bp_ready2", {31'd0, in_ready}, 32'd0);
    chk("bp_head2",  out_result, 32'h4080_0001);
    drive(1'b0, 8'h3F, 23'h2A_AAAA, 1'b0, 1'b0);
    tick();
    chk("bp_ready3", {31'd0, in_ready}, 32'd0);
    chk("bp_head3",  out_result, 32'h4080_0001);
    out_ready = 1'b1;
    tick();
    chk("bp_pop_a_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_head_b",      out_result, 32'h80FF_FFFF);
    tick();
    in_valid = 1'b0;
    chk("bp_head_c",  out_result, 32'h1FAA_AAAA);
    chk("bp_valid_c", {31'd0, out_valid}, 32'd1);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Streaming: push and pop each cycle keeps one entry in flight
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] e;
      e = 8'h10 + 8'(i);
      drive(1'b0, e, 23'(i + 1), 1'b0, 1'b0);
      tick();
      chk($sformatf("stream%0d_word", i), out_result, {1'b0, e, 23'(i + 1)});
      chk($sformatf("stream%0d_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

    // Reset mid-operation with a full FIFO
    out_ready = 1'b0;
    drive(1'b0, 8'h90, 23'h1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'h91, 23'h2, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("mid_full", {31'd0, in_ready}, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid",  {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready",  {31'd0, in_ready},  32'd1);
    chk("mid_rst_result", out_result, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 8'h85, 23'h0F_0F0F, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("post_rst_word",  out_result, 32'hC28F_0F0F);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("post_rst_pop", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
